// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 8N1 UART receiver with mid-bit sampling and one-deep holding register
module uart_rx #(
  parameter int FULL_ETU = 434,
  parameter int HALF_ETU = FULL_ETU / 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       din,
  output logic [7:0] data,
  output logic       valid,
  input  logic       ack,
  output logic       frame_err,
  output logic       overrun,
  output logic       busy
);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_START     = 3'd1;
  localparam logic [2:0] S_DATA      = 3'd2;
  localparam logic [2:0] S_STOP      = 3'd3;
  localparam logic [2:0] S_WAIT_HIGH = 3'd4;

  localparam logic [8:0] C_FULL = 9'(FULL_ETU);
  localparam logic [8:0] C_HALF = 9'(HALF_ETU);

  logic       r_sync1;
  logic       r_sync2;
  logic [2:0] r_state;
  logic [8:0] r_etu_cnt;
  logic [2:0] r_bit_cnt;
  logic [7:0] r_shreg;
  logic [7:0] r_data;
  logic       r_valid;
  logic       r_frame_err;
  logic       r_overrun;

  logic w_din_s;
  logic w_full;
  logic w_half;
  logic w_stop_pt;
  logic w_complete;
  logic w_bad_stop;

  assign w_din_s    = r_sync2;
  assign w_full     = (r_etu_cnt == C_FULL);
  assign w_half     = (r_etu_cnt == C_HALF);
  assign w_stop_pt  = (r_state == S_STOP) && w_full;
  assign w_complete = w_stop_pt && w_din_s;
  assign w_bad_stop = w_stop_pt && !w_din_s;

  assign data      = r_data;
  assign valid     = r_valid;
  assign frame_err = r_frame_err;
  assign overrun   = r_overrun;
  assign busy      = (r_state != S_IDLE);

  // Two-flop synchronizer for the asynchronous line; idles high out of reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= din;
      r_sync2 <= r_sync1;
    end
  end

  // Deframing FSM; the ETU counter restarts on every transition and sample point.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_etu_cnt <= 9'd0;
      r_bit_cnt <= 3'd0;
      r_shreg   <= 8'h00;
    end else begin
      r_etu_cnt <= r_etu_cnt + 9'd1;
      case (r_state)
        S_IDLE: begin
          if (!w_din_s) begin
            r_state   <= S_START;
            r_etu_cnt <= 9'd0;
          end
        end
        S_START: begin
          if (w_half) begin
            r_etu_cnt <= 9'd0;
            r_bit_cnt <= 3'd0;
            r_state   <= w_din_s ? S_IDLE : S_DATA;
          end
        end
        S_DATA: begin
          if (w_full) begin
            r_etu_cnt <= 9'd0;
            r_shreg   <= {w_din_s, r_shreg[7:1]};
            r_bit_cnt <= r_bit_cnt + 3'd1;
            if (r_bit_cnt == 3'd7) begin
              r_state <= S_STOP;
            end
          end
        end
        S_STOP: begin
          if (w_full) begin
            r_etu_cnt <= 9'd0;
            r_state   <= w_din_s ? S_IDLE : S_WAIT_HIGH;
          end
        end
        S_WAIT_HIGH: begin
          if (w_din_s) begin
            r_etu_cnt <= 9'd0;
            r_state   <= S_IDLE;
          end
        end
        default: begin
          r_etu_cnt <= 9'd0;
          r_state   <= S_IDLE;
        end
      endcase
    end
  end

  // Holding register and error pulses; an ack in the completion cycle frees room for the new byte.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_data      <= 8'h00;
      r_valid     <= 1'b0;
      r_frame_err <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      r_frame_err <= w_bad_stop;
      r_overrun   <= 1'b0;
      if (w_complete) begin
        if (!r_valid || ack) begin
          r_data  <= r_shreg;
          r_valid <= 1'b1;
        end else begin
          r_overrun <= 1'b1;
        end
      end else if (ack) begin
        r_valid <= 1'b0;
      end
    end
  end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
Byte-oriented UART receiver, the counterpart of the team's uart_tx. It samples the serial line at mid-bit and deframes 8N1 (start bit, 8 data bits LSB first, 1 stop bit). Each received byte goes into a one-deep holding register with a valid/ack handshake toward the host-side logic. Framing and overrun errors are reported as single-cycle pulses.

Parameters:
FULL_ETU, 434, last count of the 9-bit ETU counter; one bit period = FULL_ETU+1 clk cycles (must be <= 511; must match uart_tx).
HALF_ETU, FULL_ETU/2, start-bit mid-point count.

Ports:
clk  input  1  clock.
rst  input  1  reset, synchronous, active-high.
din  input  1  asynchronous serial line, idle high.
data  output  8  last accepted byte, stable while valid=1.
valid  output  1  level; byte in data not yet acknowledged.
ack  input  1  host consumes byte; clears valid next cycle; ignored when valid=0.
frame_err  output  1  one-cycle pulse: stop bit sampled low.
overrun  output  1  one-cycle pulse: byte completed while valid=1 and ack=0.
busy  output  1  high whenever state != IDLE.

Behaviour:
- Reset: state IDLE; sync flops=1; data=8'h00; valid=0; frame_err=0; overrun=0; busy=0; etu_cnt=0. A reset mid-frame aborts the frame with no pulses.
- din passes through a 2-flop synchronizer (din_s). All decisions use din_s only.
- 9-bit etu_cnt increments every cycle and is cleared on every state transition and every sample point.
- IDLE: din_s==0 -> START, etu_cnt<=0.
- START: at etu_cnt==HALF_ETU, sample din_s. 0 -> DATA, bit_cnt<=0. 1 -> glitch/false start, back to IDLE with no pulse.
- DATA: at etu_cnt==FULL_ETU, shift right: shreg<={din_s, shreg[7:1]} (LSB first); bit_cnt++. After the 8th sample (bit_cnt==7) -> STOP.
- STOP: at etu_cnt==FULL_ETU, sample din_s.
  - 1: byte complete -> IDLE.
  - 0: frame_err pulse; shreg discarded; -> WAIT_HIGH.
- WAIT_HIGH: stay until din_s==1, then -> IDLE. This covers the break condition, so no spurious start bit is detected.
- Sample points, relative to the cycle IDLE sees din_s==0 (detection cycle D):
  - start: D+1+HALF_ETU
  - data bit k (k=1..8): D+1+HALF_ETU+k*(FULL_ETU+1)
  - stop: k=9
- valid rises on the cycle after the stop sample.
- Byte completion, with the holding register registered on the cycle after the stop sample:
  - valid==0, or ack==1 in the completion cycle: data<=shreg, valid stays/goes 1, no overrun.
  - valid==1 and ack==0: new byte dropped, data unchanged, valid stays 1, overrun pulses for 1 cycle.
- ack with valid=1 and no completion: valid<=0 next cycle; data holds its value.
- The next frame can be detected in the cycle after returning to IDLE. Back-to-back frames from uart_tx, with its idle gap, are received without loss.
- Illegal state encoding -> IDLE.

Test Plan:
- Single frame 0xA5 at FULL_ETU=434 bit period, then ack 3 cycles after valid -> data=8'hA5, valid high exactly at stop sample+1, cleared the cycle after ack; frame_err=overrun=0 throughout.
- din low for 100 cycles then high (glitch < HALF_ETU) -> back to IDLE, valid stays 0, no pulses; a following frame 0x3C is received correctly.
- Frame 0x81 with stop bit driven 0 and line held low 2000 cycles -> one frame_err pulse, valid=0, busy stays high until din returns high, then IDLE; no extra byte.
- Frames 0x11 then 0x22 with no ack -> data=8'h11, valid=1, one overrun pulse at 0x22 completion; repeat with ack asserted in the 0x22 completion cycle -> data=8'h22, no overrun.
- rst asserted at data bit 4 of a frame -> all outputs at reset values next cycle; the remaining bits of the frame do not produce a valid byte; the next full frame 0xF0 is received.
- Loopback from uart_tx (same FULL_ETU) sending 0x00, 0xFF, 0x55, 0xAA back-to-back with ack every byte -> four bytes received in order, no errors.
